// File: rtl/sirv_uart_tx_ser.sv
// UART transmit serializer: start bit, 8 data bits LSB-first, optional parity, 1/2 stop bits.
// Optional parity bit enabled by defining SIRV_UARTTX_PARITY_EN.
module sirv_uart_tx_ser #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  output logic             io_in_ready,
  input  logic             io_in_valid,
  input  logic [7:0]       io_in_bits,
  input  logic [DIV_W-1:0] io_div,
  input  logic             io_nstop,
`ifdef SIRV_UARTTX_PARITY_EN
  input  logic             io_parity_en,
  input  logic             io_parity_odd,
`endif
  output logic             io_txd,
  output logic             io_busy
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      shreg_q, shreg_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0] prescaler_q, prescaler_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic       handshake;
  logic       par_bit;
  logic       par_used;
  logic [3:0] frame_len;

  always_comb begin
    par_bit  = 1'b1;
    par_used = 1'b0;
`ifdef SIRV_UARTTX_PARITY_EN
    par_used = io_parity_en;
    if (io_parity_en) begin
      par_bit = (^io_in_bits) ^ io_parity_odd;
    end
`endif
    frame_len = 4'd10 + {3'b000, io_nstop} + {3'b000, par_used};
  end

  // Without parity the bit-9 slot holds a 1 and simply serves as the first stop bit.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    prescaler_d = prescaler_q;
    div_d       = div_q;
    io_in_ready = io_en & (state_q == S_IDLE);
    handshake   = io_in_ready & io_in_valid;

    if (state_q == S_IDLE) begin
      if (handshake) begin
        div_d       = io_div;
        prescaler_d = io_div;
        shreg_d     = {2'b11, par_bit, io_in_bits, 1'b0};
        bitcnt_d    = frame_len;
        state_d     = S_SHIFT;
      end
    end else begin
      if (prescaler_q == '0) begin
        shreg_d     = {1'b1, shreg_q[11:1]};
        bitcnt_d    = bitcnt_q - 4'd1;
        prescaler_d = div_q;
        if (bitcnt_q == 4'd1) begin
          state_d = S_IDLE;
        end
      end else begin
        prescaler_d = prescaler_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '1;
      bitcnt_q    <= '0;
      prescaler_q <= '0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      prescaler_q <= prescaler_d;
      div_q       <= div_d;
    end
  end

  // Shift register drains to all ones by the end of a frame, so idle txd is high.
  assign io_txd  = shreg_q[0];
  assign io_busy = (state_q == S_SHIFT);

endmodule
